// File: rtl/trace_dump.sv
// ---------------------------------------------------------------------------
// trace_dump
//
// Reads a complete captured trace out of the trace RAM and hands it to a
// byte serializer, oldest sample first. When a dump is requested and the
// capture block reports a full trace, the walk starts at the address just
// after the newest sample (trace_end + 1, modulo the RAM depth). It then
// covers every RAM location exactly once and ends on trace_end. Each byte
// costs at least three cycles: a read cycle, a cycle in which the RAM data
// arrives and is registered, and a send cycle. The send cycle stretches for
// as long as the serializer is not ready.
//
// A request made while no complete trace exists is refused with a one-cycle
// nack. A request made during a dump is ignored. An abort drops back to IDLE
// without re-arming capture, so the trace stays available for another dump.
//
// Ports
//   clk              : single clock, rising edge
//   rst              : synchronous active-high reset, overrides everything
//   dump_req         : one-cycle request to read out the trace
//   dump_abort       : level, ends a dump in progress
//   capture_done     : the capture block holds a complete trace in RAM
//   trace_end        : address of the newest captured sample
//   rdata            : RAM read data, valid the cycle after en
//   tx_rdy           : serializer can accept a byte
//   addr             : RAM read address
//   en               : RAM read enable (this block never writes the RAM)
//   tx_data          : byte presented to the serializer
//   tx_start         : one-cycle strobe, tx_data valid in that cycle
//   dump_busy        : high whenever the FSM is outside IDLE
//   clr_capture_done : one-cycle pulse re-arming capture after a full dump
//   dump_done        : one-cycle pulse marking a complete dump
//   dump_nack        : one-cycle pulse when a request is refused
// ---------------------------------------------------------------------------
module trace_dump #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dump_req,
  input  logic              dump_abort,
  input  logic              capture_done,
  input  logic [ADDR_W-1:0] trace_end,
  input  logic [DATA_W-1:0] rdata,
  input  logic              tx_rdy,
  output logic [ADDR_W-1:0] addr,
  output logic              en,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  output logic              dump_busy,
  output logic              clr_capture_done,
  output logic              dump_done,
  output logic              dump_nack
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    SEND,
    FIN
  } state_t;

  // The byte counter is one bit wider than the address. That extra bit keeps
  // the count meaningful over a full pass of the RAM. The final byte of a
  // dump is the one sent while the counter holds depth-1.
  localparam logic [ADDR_W:0] LAST_CNT = {1'b0, {ADDR_W{1'b1}}};

  state_t            state;
  state_t            state_next;
  logic [ADDR_W:0]   cnt;

  // Strobes from the next-state logic that steer the datapath registers.
  logic              accept;
  logic              advance;
  logic              load_data;

  // State register. Reset wins over every other input, even mid-dump.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and output decode. en, tx_start and the completion pulses
  // come straight from the current state, so each one lasts exactly as long
  // as the state that produces it. An abort in any busy state overrides the
  // normal transition and suppresses tx_start and the completion pulses, so
  // capture_done is left set and the trace is preserved.
  always_comb begin
    state_next       = state;
    en               = 1'b0;
    tx_start         = 1'b0;
    clr_capture_done = 1'b0;
    dump_done        = 1'b0;
    accept           = 1'b0;
    advance          = 1'b0;
    load_data        = 1'b0;
    dump_busy        = (state != IDLE);

    case (state)
      IDLE: begin
        if (dump_req && capture_done) begin
          accept     = 1'b1;
          state_next = RD;
        end
      end

      RD: begin
        en         = 1'b1;
        state_next = WAIT;
      end

      WAIT: begin
        load_data  = 1'b1;
        state_next = SEND;
      end

      SEND: begin
        if (tx_rdy) begin
          tx_start = 1'b1;
          if (cnt == LAST_CNT) begin
            state_next = FIN;
          end else begin
            advance    = 1'b1;
            state_next = RD;
          end
        end
      end

      FIN: begin
        clr_capture_done = 1'b1;
        dump_done        = 1'b1;
        state_next       = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (dump_abort && (state != IDLE)) begin
      state_next       = IDLE;
      tx_start         = 1'b0;
      clr_capture_done = 1'b0;
      dump_done        = 1'b0;
      advance          = 1'b0;
      load_data        = 1'b0;
    end
  end

  // Address, byte count and outgoing byte. trace_end is only looked at when
  // a dump is accepted, so the capture side may move it freely afterwards.
  // The address is ADDR_W bits wide and simply rolls over from the top of
  // the RAM back to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr    <= '0;
      cnt     <= '0;
      tx_data <= '0;
    end else begin
      if (accept) begin
        addr <= trace_end + ADDR_W'(1);
        cnt  <= '0;
      end else if (advance) begin
        addr <= addr + ADDR_W'(1);
        cnt  <= cnt + (ADDR_W + 1)'(1);
      end
      if (load_data) begin
        tx_data <= rdata;
      end
    end
  end

  // Refusal pulse. It appears in the cycle after an unsatisfiable request.
  // It is only raised from IDLE, so a request made during a dump never
  // produces a nack.
  always_ff @(posedge clk) begin
    if (rst) begin
      dump_nack <= 1'b0;
    end else begin
      dump_nack <= (state == IDLE) && dump_req && !capture_done;
    end
  end

endmodule

// File: tb/tb_trace_dump.sv
// ---------------------------------------------------------------------------
// tb_trace_dump
//
// Self-checking bench for trace_dump. It contains a behavioural RAM filled
// with random bytes. A monitor logs every read address, every byte sent and
// every pulse. The expected dump is written directly from the intended
// behaviour: byte i of a dump is mem[(trace_end + 1 + i) mod depth], for
// i = 0 .. depth-1.
// ---------------------------------------------------------------------------
module tb_trace_dump;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic              dump_req;
  logic              dump_abort;
  logic              capture_done;
  logic [ADDR_W-1:0] trace_end;
  logic [DATA_W-1:0] rdata;
  logic              tx_rdy;
  logic [ADDR_W-1:0] addr;
  logic              en;
  logic [DATA_W-1:0] tx_data;
  logic              tx_start;
  logic              dump_busy;
  logic              clr_capture_done;
  logic              dump_done;
  logic              dump_nack;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  logic [DATA_W-1:0] mem [DEPTH];

  // Monitor log
  logic [ADDR_W-1:0] addr_q [$];
  logic [DATA_W-1:0] sent_q [$];
  int done_cnt, clr_cnt, nack_cnt, b2b_err;
  int rd_cycle, done_cycle, nack_cycle, req_cycle;
  bit rd_seen, busy_seen, prev_start;

  trace_dump #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk),
    .rst(rst),
    .dump_req(dump_req),
    .dump_abort(dump_abort),
    .capture_done(capture_done),
    .trace_end(trace_end),
    .rdata(rdata),
    .tx_rdy(tx_rdy),
    .addr(addr),
    .en(en),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .dump_busy(dump_busy),
    .clr_capture_done(clr_capture_done),
    .dump_done(dump_done),
    .dump_nack(dump_nack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM: data appears the cycle after en.
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (en) rdata <= mem[addr];
  end

  // Log everything the DUT does, sampled mid-cycle.
  always @(negedge clk) begin
    if (en) begin
      addr_q.push_back(addr);
      if (!rd_seen) begin
        rd_seen  = 1'b1;
        rd_cycle = cycle;
      end
    end
    if (tx_start) begin
      sent_q.push_back(tx_data);
      if (prev_start) b2b_err++;
    end
    prev_start = tx_start;
    if (dump_done) begin
      done_cnt++;
      done_cycle = cycle;
    end
    if (clr_capture_done) clr_cnt++;
    if (dump_nack) begin
      nack_cnt++;
      nack_cycle = cycle;
    end
    if (dump_busy) busy_seen = 1'b1;
    if (dump_req) req_cycle = cycle;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, required finish before 2ms");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    addr_q.delete();
    sent_q.delete();
    done_cnt   = 0;
    clr_cnt    = 0;
    nack_cnt   = 0;
    b2b_err    = 0;
    rd_cycle   = -1;
    done_cycle = -1;
    nack_cycle = -1;
    req_cycle  = -1;
    rd_seen    = 1'b0;
    busy_seen  = 1'b0;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
  endtask

  // Pulse a request with a full trace present. On return the DUT has
  // accepted the request and is in its first read cycle.
  task automatic start_dump(input logic [ADDR_W-1:0] te);
    trace_end    = te;
    capture_done = 1'b1;
    dump_req     = 1'b1;
    tick();
    dump_req     = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit rand_rdy, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (rand_rdy) tx_rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!dump_busy) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
  endtask

  // Count how many logged bytes differ from the reference sequence.
  function automatic int byte_mismatches(input logic [ADDR_W-1:0] te);
    int m = 0;
    for (int i = 0; i < sent_q.size() && i < DEPTH; i++)
      if (sent_q[i] !== mem[(int'(te) + 1 + i) % DEPTH]) m++;
    return m;
  endfunction

  function automatic int addr_mismatches(input logic [ADDR_W-1:0] te);
    int m = 0;
    for (int i = 0; i < addr_q.size() && i < DEPTH; i++)
      if (int'(addr_q[i]) != (int'(te) + 1 + i) % DEPTH) m++;
    return m;
  endfunction

  function automatic logic [ADDR_W-1:0] addr_at(input int i);
    if (i < addr_q.size()) return addr_q[i];
    return 'x;
  endfunction

  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++; if (addr !== '0) begin errors++; $display("[TB] FAIL reset_addr: got %h, required 0", addr); end
    checks++; if (en !== 1'b0) begin errors++; $display("[TB] FAIL reset_en: got %b, required 0", en); end
    checks++; if (tx_data !== '0) begin errors++; $display("[TB] FAIL reset_tx_data: got %h, required 0", tx_data); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_start: got %b, required 0", tx_start); end
    checks++; if (dump_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, required 0", dump_busy); end
    checks++; if ({clr_capture_done, dump_done, dump_nack} !== 3'b000) begin errors++; $display("[TB] FAIL reset_pulses: got %b, required 000", {clr_capture_done, dump_done, dump_nack}); end
    rst = 1'b0;
    tick();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_full_dump();
    bit ok;
    logic [ADDR_W-1:0] te = 9'h0A5;
    fill_mem();
    clear_log();
    tx_rdy = 1'b1;
    start_dump(te);
    // trace_end moving after acceptance must not disturb this dump
    trace_end = ADDR_W'($urandom);
    wait_idle(2000, 1'b0, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL full_timeout: idle reached=%b, required 1", ok); end
    checks++; if (addr_at(0) !== 9'h0A6) begin errors++; $display("[TB] FAIL full_first_addr: got %h, required 0a6", addr_at(0)); end
    checks++; if (addr_at(DEPTH-1) !== 9'h0A5) begin errors++; $display("[TB] FAIL full_last_addr: got %h, required 0a5", addr_at(DEPTH-1)); end
    checks++; if (sent_q.size() != DEPTH) begin errors++; $display("[TB] FAIL full_byte_count: got %0d, required %0d", sent_q.size(), DEPTH); end
    checks++; if (byte_mismatches(te) != 0) begin errors++; $display("[TB] FAIL full_bytes: mismatches=%0d, required 0", byte_mismatches(te)); end
    checks++; if (addr_mismatches(te) != 0) begin errors++; $display("[TB] FAIL full_addr_seq: mismatches=%0d, required 0", addr_mismatches(te)); end
    checks++; if (done_cnt != 1 || clr_cnt != 1) begin errors++; $display("[TB] FAIL full_done_pulses: done=%0d clr=%0d, required 1 and 1", done_cnt, clr_cnt); end
    // 1537 cycles counting both the first read cycle and the completion cycle
    checks++; if (done_cycle - rd_cycle + 1 != 3 * DEPTH + 1) begin errors++; $display("[TB] FAIL full_latency: got %0d cycles, required %0d", done_cycle - rd_cycle + 1, 3 * DEPTH + 1); end
    checks++; if (b2b_err != 0) begin errors++; $display("[TB] FAIL full_b2b_start: got %0d consecutive strobes, required 0", b2b_err); end
    checks++; if (nack_cnt != 0) begin errors++; $display("[TB] FAIL full_nack: got %0d, required 0", nack_cnt); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_wrap();
    bit ok;
    fill_mem();
    clear_log();
    tx_rdy = 1'b1;
    start_dump(9'h1FF);
    wait_idle(2000, 1'b0, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL wrap1ff_timeout: idle reached=%b, required 1", ok); end
    checks++; if (addr_at(0) !== 9'h000) begin errors++; $display("[TB] FAIL wrap1ff_first: got %h, required 000", addr_at(0)); end
    checks++; if (addr_at(DEPTH-1) !== 9'h1FF) begin errors++; $display("[TB] FAIL wrap1ff_last: got %h, required 1ff", addr_at(DEPTH-1)); end
    checks++; if (byte_mismatches(9'h1FF) != 0 || sent_q.size() != DEPTH) begin errors++; $display("[TB] FAIL wrap1ff_bytes: mismatches=%0d count=%0d, required 0 and %0d", byte_mismatches(9'h1FF), sent_q.size(), DEPTH); end

    clear_log();
    start_dump(9'h000);
    wait_idle(2000, 1'b0, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL wrap000_timeout: idle reached=%b, required 1", ok); end
    checks++; if (addr_at(DEPTH-2) !== 9'h1FF) begin errors++; $display("[TB] FAIL wrap000_byte511: got %h, required 1ff", addr_at(DEPTH-2)); end
    checks++; if (addr_at(DEPTH-1) !== 9'h000) begin errors++; $display("[TB] FAIL wrap000_byte512: got %h, required 000", addr_at(DEPTH-1)); end
    checks++; if (byte_mismatches(9'h000) != 0 || sent_q.size() != DEPTH) begin errors++; $display("[TB] FAIL wrap000_bytes: mismatches=%0d count=%0d, required 0 and %0d", byte_mismatches(9'h000), sent_q.size(), DEPTH); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_nack();
    clear_log();
    capture_done = 1'b0;
    trace_end    = ADDR_W'($urandom);
    dump_req     = 1'b1;
    tick();
    dump_req     = 1'b0;
    repeat (10) tick();
    checks++; if (nack_cnt != 1) begin errors++; $display("[TB] FAIL nack_count: got %0d, required 1", nack_cnt); end
    checks++; if (nack_cycle != req_cycle + 1) begin errors++; $display("[TB] FAIL nack_timing: got cycle %0d, required %0d", nack_cycle, req_cycle + 1); end
    checks++; if (busy_seen !== 1'b0) begin errors++; $display("[TB] FAIL nack_busy: got %b, required 0", busy_seen); end
    checks++; if (addr_q.size() != 0) begin errors++; $display("[TB] FAIL nack_en: got %0d reads, required 0", addr_q.size()); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_stall();
    bit ok;
    int stall_err = 0;
    logic [DATA_W-1:0] held;
    logic [ADDR_W-1:0] te = ADDR_W'($urandom);
    fill_mem();
    clear_log();
    tx_rdy = 1'b0;
    start_dump(te);
    @(negedge clk);
    checks++; if (en !== 1'b1) begin errors++; $display("[TB] FAIL stall_rd_entry: en=%b, required 1", en); end
    tick();
    tick();
    @(negedge clk);
    held = tx_data;
    checks++; if (held !== mem[(int'(te) + 1) % DEPTH]) begin errors++; $display("[TB] FAIL stall_first_byte: got %h, required %h", held, mem[(int'(te) + 1) % DEPTH]); end
    for (int k = 0; k < 20; k++) begin
      tick();
      @(negedge clk);
      if (tx_start !== 1'b0) stall_err++;
      if (tx_data !== held) stall_err++;
    end
    checks++; if (stall_err != 0) begin errors++; $display("[TB] FAIL stall_hold: got %0d violations, required 0", stall_err); end
    tick();
    tx_rdy = 1'b1;
    @(negedge clk);
    checks++; if (tx_start !== 1'b1) begin errors++; $display("[TB] FAIL stall_release: tx_start=%b, required 1", tx_start); end
    wait_idle(8000, 1'b1, ok);
    tx_rdy = 1'b1;
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL stall_timeout: idle reached=%b, required 1", ok); end
    checks++; if (sent_q.size() != DEPTH) begin errors++; $display("[TB] FAIL stall_byte_count: got %0d, required %0d", sent_q.size(), DEPTH); end
    checks++; if (byte_mismatches(te) != 0) begin errors++; $display("[TB] FAIL stall_bytes: mismatches=%0d, required 0", byte_mismatches(te)); end
    checks++; if (b2b_err != 0) begin errors++; $display("[TB] FAIL stall_b2b_start: got %0d, required 0", b2b_err); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_abort();
    bit ok;
    int n = 0;
    logic [ADDR_W-1:0] te = ADDR_W'($urandom);
    fill_mem();
    clear_log();
    tx_rdy = 1'b1;
    start_dump(te);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (tx_start) n++;
      if (n == 100) break;
      tick();
    end
    checks++; if (n != 100) begin errors++; $display("[TB] FAIL abort_reach100: got %0d bytes, required 100", n); end
    // read, data and send cycles of byte 101; abort lands in the send cycle
    tick();
    tick();
    tick();
    dump_abort = 1'b1;
    @(negedge clk);
    checks++; if (tx_start !== 1'b0) begin errors++; $display("[TB] FAIL abort_no_start: tx_start=%b, required 0", tx_start); end
    tick();
    dump_abort = 1'b0;
    @(negedge clk);
    checks++; if (dump_busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_idle: busy=%b, required 0", dump_busy); end
    repeat (5) tick();
    checks++; if (done_cnt != 0 || clr_cnt != 0) begin errors++; $display("[TB] FAIL abort_pulses: done=%0d clr=%0d, required 0 and 0", done_cnt, clr_cnt); end
    checks++; if (sent_q.size() != 100) begin errors++; $display("[TB] FAIL abort_bytes: got %0d, required 100", sent_q.size()); end

    clear_log();
    start_dump(te);
    wait_idle(2000, 1'b0, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL abort_restart_timeout: idle reached=%b, required 1", ok); end
    checks++; if (int'(addr_at(0)) != (int'(te) + 1) % DEPTH) begin errors++; $display("[TB] FAIL abort_restart_first: got %h, required %h", addr_at(0), ADDR_W'(te + 1)); end
    checks++; if (sent_q.size() != DEPTH || byte_mismatches(te) != 0) begin errors++; $display("[TB] FAIL abort_restart_bytes: count=%0d mismatches=%0d, required %0d and 0", sent_q.size(), byte_mismatches(te), DEPTH); end
    checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL abort_restart_done: got %0d, required 1", done_cnt); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_back_to_back();
    logic [ADDR_W-1:0] te = ADDR_W'($urandom);
    fill_mem();
    clear_log();
    tx_rdy = 1'b1;
    start_dump(te);
    repeat (40) tick();
    // second request while busy must be ignored
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    repeat (40) tick();
    tx_rdy = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    checks++; if (dump_busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_still_busy: busy=%b, required 1", dump_busy); end
    checks++; if (nack_cnt != 0) begin errors++; $display("[TB] FAIL b2b_no_nack: got %0d, required 0", nack_cnt); end
    checks++; if (addr_mismatches(te) != 0 || addr_q.size() < 20) begin errors++; $display("[TB] FAIL b2b_no_restart: mismatches=%0d reads=%0d, required 0 and at least 20", addr_mismatches(te), addr_q.size()); end
    // reset while stalled in the send state, racing a new request
    rst      = 1'b1;
    tx_rdy   = 1'b1;
    dump_req = 1'b1;
    tick();
    rst      = 1'b0;
    dump_req = 1'b0;
    tx_rdy   = 1'b0;
    @(negedge clk);
    checks++; if ({addr, tx_data} !== '0) begin errors++; $display("[TB] FAIL midrst_regs: addr=%h tx_data=%h, required 0 and 0", addr, tx_data); end
    checks++; if ({en, tx_start, dump_busy, clr_capture_done, dump_done, dump_nack} !== 6'b0) begin errors++; $display("[TB] FAIL midrst_ctrl: got %b, required 000000", {en, tx_start, dump_busy, clr_capture_done, dump_done, dump_nack}); end
    repeat (5) tick();
    checks++; if (dump_busy !== 1'b0 || done_cnt != 0 || nack_cnt != 0) begin errors++; $display("[TB] FAIL midrst_after: busy=%b done=%0d nack=%0d, required 0, 0, 0", dump_busy, done_cnt, nack_cnt); end
  endtask

  initial begin
    rst          = 1'b1;
    dump_req     = 1'b0;
    dump_abort   = 1'b0;
    capture_done = 1'b0;
    trace_end    = '0;
    tx_rdy       = 1'b0;
    rdata        = '0;
    clear_log();
    test_reset();
    test_full_dump();
    test_wrap();
    test_nack();
    test_stall();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trace_dump.md
TRACE_DUMP -- requirements
Module: trace_dump

Interface
REQ-001 Parameter ADDR_W, default 9, trace RAM address width; depth = 2^ADDR_W = 512 samples.
REQ-002 Parameter DATA_W, default 8, sample width in bits.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 dump_req  input  1  one-cycle pulse requesting readout of the captured trace.
REQ-006 dump_abort  input  1  level; terminates a dump in progress.
REQ-007 capture_done  input  1  capture block has a complete trace in RAM.
REQ-008 trace_end  input  ADDR_W  address of the newest sample written by capture.
REQ-009 rdata  input  DATA_W  RAM read data, valid one cycle after en=1.
REQ-010 tx_rdy  input  1  downstream serializer can accept a byte.
REQ-011 addr  output  ADDR_W  RAM read address.
REQ-012 en  output  1  RAM read enable; we is never driven by this block.
REQ-013 tx_data  output  DATA_W  byte to serializer.
REQ-014 tx_start  output  1  one-cycle pulse; tx_data is valid in that cycle.
REQ-015 dump_busy  output  1  high in every state except IDLE.
REQ-016 clr_capture_done  output  1  one-cycle pulse that re-arms capture after a complete dump.
REQ-017 dump_done  output  1  one-cycle pulse marking a complete dump.
REQ-018 dump_nack  output  1  one-cycle pulse when a request is refused.

Function
REQ-019 FSM states: IDLE, RD, WAIT, SEND, FIN; these are the only states.
REQ-020 IDLE: dump_req=1 and capture_done=1 -> RD; load addr=trace_end+1 (mod 2^ADDR_W) and cnt=0.
REQ-021 IDLE: dump_req=1 and capture_done=0 -> stay IDLE; dump_nack=1 in the next cycle only.
REQ-022 RD: en=1 for exactly one cycle -> WAIT.
REQ-023 WAIT: register rdata into tx_data at the end of the cycle -> SEND.
REQ-024 SEND with tx_rdy=0: hold; tx_start=0; tx_data stable.
REQ-025 SEND with tx_rdy=1: tx_start=1 for that cycle.
  - cnt=2^ADDR_W-1 -> FIN.
  - otherwise addr+1 (wraps 511->0), cnt+1 -> RD.
REQ-026 cnt is ADDR_W+1 bits wide; exactly 2^ADDR_W bytes are sent per dump, oldest (trace_end+1) first and newest (trace_end) last.
REQ-027 FIN: clr_capture_done=1 and dump_done=1 for one cycle -> IDLE.
REQ-028 Minimum cost is 3 cycles per byte (RD, WAIT, SEND); a dump with tx_rdy held high takes 3*512+1 cycles from RD entry to IDLE.
REQ-029 dump_req while dump_busy=1 is ignored: no nack and no restart.
REQ-030 dump_abort=1 in any non-IDLE state -> IDLE next cycle.
  - no tx_start in that cycle.
  - clr_capture_done and dump_done are not pulsed, so the trace is preserved.
REQ-031 dump_abort takes priority over tx_rdy in SEND.
REQ-032 trace_end is sampled only on IDLE->RD; later changes have no effect on the current dump.
REQ-033 tx_data is updated only in WAIT; tx_start never asserts in two consecutive cycles.

Reset
REQ-034 rst=1 at a clock edge -> state IDLE; rst has priority over all other inputs, including mid-dump.
REQ-035 Reset values: addr=0, cnt=0, tx_data=0, en=0, tx_start=0, dump_busy=0, clr_capture_done=0, dump_done=0, dump_nack=0.

Verification
REQ-036 capture_done=1, trace_end=0x0A5, dump_req pulse, tx_rdy=1 -> checks:
  - first RD addr=0x0A6;
  - 512 tx_start pulses, last byte from addr 0x0A5;
  - dump_done and clr_capture_done pulse once, 1537 cycles after RD entry.
REQ-037 trace_end=0x1FF -> first addr=0x000 and last addr=0x1FF; trace_end=0x000 -> addr wraps 0x1FF->0x000 after 511 bytes.
REQ-038 capture_done=0, dump_req pulse -> dump_nack=1 for one cycle, dump_busy stays 0, en never asserts.
REQ-039 tx_rdy=0 for 20 cycles in SEND -> tx_start=0 and tx_data constant throughout; tx_rdy rising -> single tx_start pulse; byte sequence equals RAM model contents.
REQ-040 dump_abort after byte 100 -> IDLE next cycle, no clr_capture_done; a new dump_req then restarts at trace_end+1 and sends 512 bytes.
REQ-041 rst=1 mid-SEND and second dump_req mid-dump -> all outputs reset the next cycle; the ignored request causes no restart and no nack.
